// File: rtl/oh_fifo_pkg.sv
// oh_fifo_pkg: read-mode constants, clog2 and parameter legality checks for oh_fifo_sync.
`ifndef OH_FIFO_PKG_MACROS
`define OH_FIFO_PKG_MACROS
`define OH_FIFO_IS_POW2(x) (((x) > 0) && (((x) & ((x) - 1)) == 0))
`define OH_FIFO_IN_RANGE(v, lo, hi) (((v) >= (lo)) && ((v) <= (hi)))
`endif
package oh_fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic params_ok(input int depth, input int pf, input int pe, input int mode);
    return `OH_FIFO_IS_POW2(depth) && (depth >= 4) &&
           `OH_FIFO_IN_RANGE(pf, 1, depth) && `OH_FIFO_IN_RANGE(pe, 0, depth - 1) &&
           `OH_FIFO_IN_RANGE(mode, FIFO_MODE_STD, FIFO_MODE_FWFT);
  endfunction
endpackage

// File: rtl/oh_fifo_sync_mem.sv
// oh_fifo_sync_mem: DW x DEPTH simple dual-port array, synchronous write, asynchronous read, no reset.
module oh_fifo_sync_mem #(
  parameter int DW = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= din;
  assign dout = mem[raddr];
endmodule

// File: rtl/oh_fifo_sync.sv
// oh_fifo_sync: single-clock FIFO with optional first-word-fall-through, occupancy count,
// programmable thresholds, sticky overflow/underflow and synchronous flush.
module oh_fifo_sync
  import oh_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 16,
  parameter int FWFT = FIFO_MODE_STD,
  parameter int PROG_FULL = DEPTH / 2,
  parameter int PROG_EMPTY = 1,
  parameter int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          prog_full,
  output logic          overflow,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          prog_empty,
  output logic          underflow,
  output logic [AW:0]   count
);
  if (!params_ok(DEPTH, PROG_FULL, PROG_EMPTY, FWFT)) begin : g_bad_params
    $error("oh_fifo_sync: illegal DEPTH/PROG_FULL/PROG_EMPTY/FWFT");
  end
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_PF = (AW + 1)'(PROG_FULL);
  localparam logic [AW:0] CNT_PE = (AW + 1)'(PROG_EMPTY);
  localparam logic IS_FWFT = FWFT == FIFO_MODE_FWFT;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem_q;
  logic [AW:0] cnt_nxt;
  logic out_valid, wr_ok, rd_ok, arr_empty, bypass, pop_arr, mem_we;
  assign full = count == CNT_FULL;
  assign empty = IS_FWFT ? ~out_valid : count == '0;
  assign prog_full = count >= CNT_PF;
  assign prog_empty = count <= CNT_PE;
  // In FWFT the output register is counted, so the array holds count - out_valid entries.
  always_comb begin
    wr_ok = wr_en & ~full;
    rd_ok = rd_en & ~empty;
    arr_empty = count == {{AW{1'b0}}, out_valid};
    bypass = IS_FWFT & wr_ok & (~out_valid | (rd_ok & arr_empty));
    pop_arr = rd_ok & ~arr_empty;
    mem_we = wr_ok & ~bypass;
    cnt_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
  end
  oh_fifo_sync_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(mem_we), .waddr(wr_ptr), .din(din), .raddr(rd_ptr), .dout(mem_q)
  );
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      dout <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= clear ? '0 : wr_ptr + AW'(mem_we);
      rd_ptr <= clear ? '0 : rd_ptr + AW'(pop_arr);
      count <= clear ? '0 : cnt_nxt;
      out_valid <= ~clear & IS_FWFT & (cnt_nxt != '0);
      dout <= clear ? '0 : pop_arr ? mem_q : bypass ? din : dout;
      overflow <= ~clear & (overflow | (wr_en & full));
      underflow <= ~clear & (underflow | (rd_en & empty));
    end
endmodule

// File: tb/tb_oh_fifo_sync.sv
// tb_oh_fifo_sync: directed checks of oh_fifo_sync in standard and FWFT modes.
module tb_oh_fifo_sync;
  logic clk = 1'b0, nreset = 1'b0;
  logic s_clear = 0, s_wr = 0, s_rd = 0, f_clear = 0, f_wr = 0, f_rd = 0;
  logic [31:0] s_din = '0, f_din = '0, s_dout, f_dout;
  logic s_full, s_pfull, s_ovf, s_emp, s_pempty, s_unf;
  logic f_full, f_pfull, f_ovf, f_emp, f_pempty, f_unf;
  logic [4:0] s_cnt, f_cnt;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic c, w, r;
    logic [31:0] d;
    int cnt;
    logic emp;
    logic [31:0] q;
    logic ovf, unf;
  } vec_t;
  vec_t vec[12];
  always #5 clk = ~clk;
  oh_fifo_sync #(.FWFT(0)) dut_s (
    .clk(clk), .nreset(nreset), .clear(s_clear), .wr_en(s_wr), .din(s_din),
    .full(s_full), .prog_full(s_pfull), .overflow(s_ovf), .rd_en(s_rd), .dout(s_dout),
    .empty(s_emp), .prog_empty(s_pempty), .underflow(s_unf), .count(s_cnt)
  );
  oh_fifo_sync #(.FWFT(1)) dut_f (
    .clk(clk), .nreset(nreset), .clear(f_clear), .wr_en(f_wr), .din(f_din),
    .full(f_full), .prog_full(f_pfull), .overflow(f_ovf), .rd_en(f_rd), .dout(f_dout),
    .empty(f_emp), .prog_empty(f_pempty), .underflow(f_unf), .count(f_cnt)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic s_cyc(input logic c, input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    s_clear = c; s_wr = w; s_rd = r; s_din = d;
    @(posedge clk);
    #1;
    s_clear = 0; s_wr = 0; s_rd = 0;
  endtask
  task automatic f_cyc(input logic c, input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    f_clear = c; f_wr = w; f_rd = r; f_din = d;
    @(posedge clk);
    #1;
    f_clear = 0; f_wr = 0; f_rd = 0;
  endtask
  task automatic f_chk(input string nm, input int cnt, input logic emp, input logic [31:0] q);
    chk({nm, "_cnt"}, 32'(f_cnt), cnt);
    chk({nm, "_empty"}, 32'(f_emp), 32'(emp));
    chk({nm, "_dout"}, f_dout, q);
  endtask
  initial begin
    //          c  w  r  din        cnt emp dout       ovf unf
    vec[0]  = '{1, 0, 0, 32'h0,     0,  1,  32'h0,     0,  0};
    vec[1]  = '{0, 0, 1, 32'h0,     0,  1,  32'h0,     0,  1};
    vec[2]  = '{0, 1, 0, 32'h11,    1,  0,  32'h0,     0,  1};
    vec[3]  = '{0, 1, 0, 32'h22,    2,  0,  32'h0,     0,  1};
    vec[4]  = '{0, 1, 1, 32'h33,    2,  0,  32'h11,    0,  1};
    vec[5]  = '{0, 0, 1, 32'h0,     1,  0,  32'h22,    0,  1};
    vec[6]  = '{0, 1, 1, 32'h44,    1,  0,  32'h33,    0,  1};
    vec[7]  = '{0, 0, 1, 32'h0,     0,  1,  32'h44,    0,  1};
    vec[8]  = '{0, 0, 0, 32'h0,     0,  1,  32'h44,    0,  1};
    vec[9]  = '{1, 1, 1, 32'h55,    0,  1,  32'h0,     0,  0};
    vec[10] = '{0, 1, 1, 32'h66,    1,  0,  32'h0,     0,  1};
    vec[11] = '{1, 0, 0, 32'h0,     0,  1,  32'h0,     0,  0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cnt", 32'(s_cnt), 0);
    chk("rst_s_empty", 32'(s_emp), 1);
    chk("rst_s_pempty", 32'(s_pempty), 1);
    chk("rst_s_full", 32'(s_full), 0);
    chk("rst_s_pfull", 32'(s_pfull), 0);
    chk("rst_s_dout", s_dout, 0);
    chk("rst_s_flags", {30'd0, s_ovf, s_unf}, 0);
    f_chk("rst_f", 0, 1, 0);
    @(negedge clk);
    nreset = 1;
    for (int i = 0; i < 16; i++) begin
      s_cyc(0, 1, 0, 32'hA0 + i);
      chk("fill_cnt", 32'(s_cnt), i + 1);
      chk("fill_pfull", 32'(s_pfull), 32'((i + 1) >= 8));
      chk("fill_full", 32'(s_full), 32'(i == 15));
      chk("fill_pempty", 32'(s_pempty), 32'(i == 0));
    end
    s_cyc(0, 1, 0, 32'hFF);
    chk("ovf_flag", 32'(s_ovf), 1);
    chk("ovf_cnt", 32'(s_cnt), 16);
    chk("ovf_dout", s_dout, 0);
    for (int i = 0; i < 16; i++) begin
      s_cyc(0, 0, 1, 0);
      chk("drain_dout", s_dout, 32'hA0 + i);
      chk("drain_cnt", 32'(s_cnt), 15 - i);
      chk("drain_empty", 32'(s_emp), 32'(i == 15));
    end
    for (int i = 0; i < 12; i++) begin
      s_cyc(vec[i].c, vec[i].w, vec[i].r, vec[i].d);
      chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), vec[i].cnt);
      chk($sformatf("vec%0d_empty", i), 32'(s_emp), 32'(vec[i].emp));
      chk($sformatf("vec%0d_dout", i), s_dout, vec[i].q);
      chk($sformatf("vec%0d_ovf", i), 32'(s_ovf), 32'(vec[i].ovf));
      chk($sformatf("vec%0d_unf", i), 32'(s_unf), 32'(vec[i].unf));
    end
    for (int i = 0; i < 5; i++) s_cyc(0, 1, 0, 32'hB0 + i);
    chk("wrap_pre_cnt", 32'(s_cnt), 5);
    for (int i = 0; i < 20; i++) begin
      s_cyc(0, 1, 1, 32'hB5 + i);
      chk("wrap_cnt", 32'(s_cnt), 5);
      chk("wrap_dout", s_dout, 32'hB0 + i);
    end
    s_cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) s_cyc(0, 1, 0, 32'hC0 + i);
    chk("full_full", 32'(s_full), 1);
    s_cyc(0, 1, 1, 32'hEE);
    chk("fullrw_cnt", 32'(s_cnt), 15);
    chk("fullrw_dout", s_dout, 32'hC0);
    chk("fullrw_ovf", 32'(s_ovf), 1);
    chk("fullrw_full", 32'(s_full), 0);
    for (int i = 1; i < 16; i++) begin
      s_cyc(0, 0, 1, 0);
      chk("fullrd_dout", s_dout, 32'hC0 + i);
    end
    chk("fullrd_empty", 32'(s_emp), 1);
    s_cyc(0, 0, 1, 0);
    chk("unf_flag", 32'(s_unf), 1);
    chk("unf_dout", s_dout, 32'hCF);
    chk("unf_cnt", 32'(s_cnt), 0);
    for (int i = 0; i < 9; i++) s_cyc(0, 1, 0, 32'hD0 + i);
    chk("clr_pre_cnt", 32'(s_cnt), 9);
    s_cyc(1, 1, 0, 32'h99);
    chk("clr_cnt", 32'(s_cnt), 0);
    chk("clr_empty", 32'(s_emp), 1);
    chk("clr_dout", s_dout, 0);
    chk("clr_flags", {30'd0, s_ovf, s_unf}, 0);
    f_cyc(0, 1, 0, 32'h55); f_chk("f_w55", 1, 0, 32'h55);
    f_cyc(0, 0, 1, 0);      f_chk("f_r55", 0, 1, 32'h55);
    chk("f_r55_unf", 32'(f_unf), 0);
    f_cyc(0, 1, 0, 32'h1);  f_chk("f_w1", 1, 0, 32'h1);
    f_cyc(0, 1, 0, 32'h2);  f_chk("f_w2", 2, 0, 32'h1);
    f_cyc(0, 1, 0, 32'h3);  f_chk("f_w3", 3, 0, 32'h1);
    f_cyc(0, 0, 1, 0);      f_chk("f_r1", 2, 0, 32'h2);
    f_cyc(0, 1, 1, 32'h4);  f_chk("f_rw4", 2, 0, 32'h3);
    f_cyc(0, 0, 1, 0);      f_chk("f_r3", 1, 0, 32'h4);
    f_cyc(0, 1, 1, 32'h5);  f_chk("f_bypass5", 1, 0, 32'h5);
    f_cyc(0, 0, 1, 0);      f_chk("f_r5", 0, 1, 32'h5);
    f_cyc(0, 0, 1, 0);
    chk("f_unf", 32'(f_unf), 1);
    for (int i = 0; i < 16; i++) begin
      f_cyc(0, 1, 0, 32'h60 + i);
      f_chk("f_fill", i + 1, 0, 32'h60);
      chk("f_fill_full", 32'(f_full), 32'(i == 15));
      chk("f_fill_pfull", 32'(f_pfull), 32'((i + 1) >= 8));
    end
    f_cyc(0, 1, 0, 32'hFF);
    chk("f_ovf", 32'(f_ovf), 1);
    chk("f_ovf_cnt", 32'(f_cnt), 16);
    f_cyc(0, 1, 1, 32'hEE); f_chk("f_fullrw", 15, 0, 32'h61);
    f_cyc(1, 0, 0, 0);      f_chk("f_clr", 0, 1, 0);
    chk("f_clr_flags", {30'd0, f_ovf, f_unf}, 0);
    @(negedge clk);
    s_wr = 1; s_din = 32'h77; f_wr = 1; f_din = 32'h88;
    @(posedge clk);
    #1;
    s_rd = 1;
    @(posedge clk);
    #1;
    chk("burst_s_dout", s_dout, 32'h77);
    f_chk("burst_f", 2, 0, 32'h88);
    nreset = 0;
    #1;
    chk("arst_s_cnt", 32'(s_cnt), 0);
    chk("arst_s_empty", 32'(s_emp), 1);
    chk("arst_s_dout", s_dout, 0);
    chk("arst_s_pempty", 32'(s_pempty), 1);
    f_chk("arst_f", 0, 1, 0);
    s_wr = 0; s_rd = 0; f_wr = 0;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
